// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter sharing a byte-wide ROM; each grant fetches a
// 16-bit little-endian word (two byte reads) and returns it to the owner port.
module rom_arbiter #(
  parameter int unsigned size_addr = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [size_addr-1:0] addr0,
  output logic                 ack0,
  output logic [15:0]          data0,
  input  logic                 req1,
  input  logic [size_addr-1:0] addr1,
  output logic                 ack1,
  output logic [15:0]          data1,
  output logic                 rom_read,
  output logic [size_addr-1:0] rom_address,
  input  logic                 rom_ready,
  input  logic [7:0]           rom_data,
  output logic                 busy,
  output logic                 owner
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]           state, state_nx;
  logic                 prio, prio_nx;
  logic [BYTE_W-1:0]    lo_byte, lo_byte_nx;
  logic                 rom_read_nx;
  logic [size_addr-1:0] rom_address_nx;
  logic                 ack0_nx, ack1_nx;
  logic [WORD_W-1:0]    data0_nx, data1_nx;
  logic                 busy_nx;
  logic                 owner_nx;
  logic                 grant;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      lo_byte     <= '0;
      rom_read    <= 1'b0;
      rom_address <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      data0       <= '0;
      data1       <= '0;
      busy        <= 1'b0;
      owner       <= 1'b0;
    end else begin
      state       <= state_nx;
      prio        <= prio_nx;
      lo_byte     <= lo_byte_nx;
      rom_read    <= rom_read_nx;
      rom_address <= rom_address_nx;
      ack0        <= ack0_nx;
      ack1        <= ack1_nx;
      data0       <= data0_nx;
      data1       <= data1_nx;
      busy        <= busy_nx;
      owner       <= owner_nx;
    end
  end

  // Port 1 wins when it is the sole requester, or when both request and it holds priority
  assign grant = req1 & (~req0 | prio);

  // Next-state and next-output logic
  always_comb begin
    state_nx       = state;
    prio_nx        = prio;
    lo_byte_nx     = lo_byte;
    rom_read_nx    = 1'b0;
    rom_address_nx = rom_address;
    ack0_nx        = 1'b0;
    ack1_nx        = 1'b0;
    data0_nx       = data0;
    data1_nx       = data1;
    owner_nx       = owner;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nx       = grant;
          prio_nx        = ~grant;
          rom_address_nx = grant ? addr1 : addr0;
          rom_read_nx    = 1'b1;
          state_nx       = LO;
        end
      end
      LO: begin
        if (rom_ready) begin
          lo_byte_nx     = rom_data;
          rom_address_nx = size_addr'(rom_address + size_addr'(1));
          rom_read_nx    = 1'b1;
          state_nx       = HI;
        end
      end
      HI: begin
        if (rom_ready) begin
          if (owner) begin
            data1_nx = {rom_data, lo_byte};
            ack1_nx  = 1'b1;
          end else begin
            data0_nx = {rom_data, lo_byte};
            ack0_nx  = 1'b1;
          end
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: table of single transactions, then hand
// sequences for back-to-back round-robin and reset during a fetch.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [7:0]  addr0, addr1;
  logic        ack0, ack1;
  logic [15:0] data0, data1;
  logic        rom_read;
  logic [7:0]  rom_address;
  logic        rom_ready;
  logic [7:0]  rom_data;
  logic        busy;
  logic        owner;

  rom_arbiter #(.size_addr(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .addr0       (addr0),
    .ack0        (ack0),
    .data0       (data0),
    .req1        (req1),
    .addr1       (addr1),
    .ack1        (ack1),
    .data1       (data1),
    .rom_read    (rom_read),
    .rom_address (rom_address),
    .rom_ready   (rom_ready),
    .rom_data    (rom_data),
    .busy        (busy),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ROM model: answers one cycle after sampling rom_read, plus 'extra' wait cycles
  logic [7:0] mem [256];
  int         extra = 0;
  int         r_wait = 0;
  logic [7:0] r_addr = '0;
  int         rd_count = 0;
  logic [7:0] rd_q [$];

  always @(posedge clk) begin
    rom_ready <= 1'b0;
    if (rom_read) begin
      rd_count = rd_count + 1;
      rd_q.push_back(rom_address);
      r_addr <= rom_address;
      if (extra == 0) begin
        rom_ready <= 1'b1;
        rom_data  <= mem[rom_address];
      end else begin
        r_wait <= extra;
      end
    end else if (r_wait != 0) begin
      r_wait <= r_wait - 1;
      if (r_wait == 1) begin
        rom_ready <= 1'b1;
        rom_data  <= mem[r_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        r0;
    logic        r1;
    logic [7:0]  a0;
    logic [7:0]  a1;
    int          extra;
    logic        exp_owner;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] m_data [2];

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; extra = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_data[0] = '0;
    m_data[1] = '0;
  endtask

  // One transaction: grant, latency to ack, word, untouched other port, ROM addresses
  task automatic run_vec(input vec_t v);
    int          lat;
    logic        got, other_ack;
    int          busy_low;
    logic [7:0]  b, b1;
    logic [15:0] got_data, other_data;
    @(negedge clk);
    req0 = v.r0; req1 = v.r1; addr0 = v.a0; addr1 = v.a1; extra = v.extra;
    rd_q.delete();
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; addr0 = ~v.a0; addr1 = ~v.a1;
    check("grant_owner", 32'(owner), 32'(v.exp_owner));
    lat = 0; got = 1'b0; other_ack = 1'b0; busy_low = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      if (!busy) busy_low++;
      @(posedge clk); #1;
      if (v.exp_owner ? ack0 : ack1) other_ack = 1'b1;
      if (v.exp_owner ? ack1 : ack0) begin got = 1'b1; lat = k; end
    end
    check("ack_latency", 32'(lat), 32'(v.exp_lat));
    check("busy_during", 32'(busy_low), 32'd0);
    got_data   = v.exp_owner ? data1 : data0;
    other_data = v.exp_owner ? data0 : data1;
    check("owner_data", 32'(got_data), 32'(v.exp_data));
    check("other_data_held", 32'(other_data), 32'(m_data[!v.exp_owner]));
    check("other_ack_low", 32'(other_ack), 32'd0);
    b  = v.exp_owner ? v.a1 : v.a0;
    b1 = b + 8'd1;
    check("rom_reads", 32'(rd_q.size()), 32'd2);
    if (rd_q.size() >= 2) begin
      check("rom_addr_lo", 32'(rd_q[0]), 32'(b));
      check("rom_addr_hi", 32'(rd_q[1]), 32'(b1));
    end
    m_data[v.exp_owner] = v.exp_data;
    @(posedge clk); #1;
    check("ack_single", 32'({ack0, ack1}), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int   n_acks;
    int   ord [4];
    int   pulses;
    logic both;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
    mem[8'h20] = 8'hCD; mem[8'h21] = 8'hAB;
    mem[8'hFF] = 8'h78; mem[8'h00] = 8'h56;
    mem[8'h40] = 8'hEF; mem[8'h41] = 8'hBE;

    //          r0    r1    a0     a1     ex own   data      lat
    vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 0, 1'b0, 16'h1234, 4};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h20, 0, 1'b1, 16'hABCD, 4};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'hFF, 0, 1'b1, 16'h5678, 4};
    vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 3, 1'b0, 16'h1234, 10};
    vecs[4] = '{1'b1, 1'b0, 8'h40, 8'h00, 0, 1'b0, 16'hBEEF, 4};
    vecs[5] = '{1'b1, 1'b1, 8'h10, 8'h20, 0, 1'b1, 16'hABCD, 4};
    vecs[6] = '{1'b1, 1'b1, 8'h40, 8'hFF, 2, 1'b0, 16'hBEEF, 8};

    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    #2 rst_n = 1'b0;
    #3;
    check("rst_rom_read", 32'(rom_read), 32'd0);
    check("rst_rom_address", 32'(rom_address), 32'd0);
    check("rst_acks", 32'({ack0, ack1}), 32'd0);
    check("rst_data0", 32'(data0), 32'd0);
    check("rst_data1", 32'(data1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    do_reset();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Both ports held high across four transactions
    do_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h20;
    rd_count = 0; n_acks = 0; both = 1'b0;
    for (int k = 0; k < 100 && n_acks < 4; k++) begin
      @(posedge clk); #1;
      if (ack0 && ack1) both = 1'b1;
      if (ack0 || ack1) begin
        ord[n_acks] = ack1 ? 1 : 0;
        check("rr_owner", 32'(owner), 32'(n_acks % 2));
        if (n_acks == 0) check("rr_data0", 32'(data0), 32'h1234);
        if (n_acks == 1) check("rr_data1", 32'(data1), 32'hABCD);
        n_acks++;
        if (n_acks == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    check("rr_ack_count", 32'(n_acks), 32'd4);
    for (int i = 0; i < n_acks; i++) check("rr_order", 32'(ord[i]), 32'(i % 2));
    check("rr_ack_overlap", 32'(both), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rr_rom_reads", 32'(rd_count), 32'd8);
    check("rr_idle", 32'(busy), 32'd0);

    // Reset while fetching the high byte
    @(negedge clk);
    req0 = 1'b1; addr0 = 8'h10;
    pulses = 0;
    for (int k = 0; k < 20 && pulses < 2; k++) begin
      @(posedge clk); #1;
      if (k == 0) req0 = 1'b0;
      if (rom_read) pulses++;
    end
    check("hi_reached", 32'(pulses), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rom_read", 32'(rom_read), 32'd0);
    check("abort_rom_address", 32'(rom_address), 32'd0);
    check("abort_data0", 32'(data0), 32'd0);
    check("abort_data1", 32'(data1), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_owner", 32'(owner), 32'd0);
    both = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ack0 || ack1) both = 1'b1;
    end
    check("abort_no_ack", 32'(both), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_data[0] = '0;
    m_data[1] = '0;
    run_vec('{1'b1, 1'b1, 8'h10, 8'h20, 0, 1'b0, 16'h1234, 4});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
